cache_refill_ctrl: RTL and testbench
====================================

Name: cache_refill_ctrl

Overview:
Memory-side line engine for cache_set and cache_way: it is the responder to the cache's miss/load interface.
- On a miss it writes back the dirty victim line, then fetches the new line as 32-bit beats from the memory bus.
- It assembles the beats into a 128-bit line and drives it into the cache's ldata/load_en/begin_load inputs.
- It sits between cache_set and the external word-wide memory port.

Parameters:
LINE_WORDS, 4, 32-bit words per cache line (line = 128 bits)
ADDR_W, 32, byte-address width

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
miss_req_in  input  1  cache requests a line fill (sampled in IDLE only)
miss_addr_in  input  32  address of missing line; low 4 bits ignored
dirty_in  input  1  victim line is dirty; sampled with miss_req_in
wb_addr_in  input  32  victim line address; low 4 bits ignored
wbdata_in  input  128  victim line data; word k = bits [32k+31:32k]
ldata_out  output  128  assembled fill line, to cache ldata input
begin_load_out  output  1  to cache begin_load
load_en_out  output  1  one-cycle line write strobe, to cache load_en
ready_out  output  1  engine idle; cache may issue miss_req_in
mem_req_out  output  1  memory beat request
mem_we_out  output  1  1 = write beat, 0 = read beat
mem_addr_out  output  32  word address of the current beat
mem_wdata_out  output  32  write beat data
mem_rdata_in  input  32  read beat data, valid when mem_ack_in=1
mem_ack_in  input  1  beat accepted/completed this cycle

Behaviour:
- Reset (rst=0, async): state=IDLE, beat counter=0. Outputs: ldata_out=0, begin_load_out=0, load_en_out=0, ready_out=1, mem_req_out=0, mem_we_out=0, mem_addr_out=0, mem_wdata_out=0.
- Reset mid-transfer aborts immediately. No partial line is ever loaded, and load_en_out is never asserted on the abort path.
- All outputs are registered.
- State IDLE: ready_out=1. If miss_req_in=1, latch {miss_addr[31:4], dirty, wb_addr[31:4], wbdata}, drop ready_out next cycle, and go to WB if dirty_in=1, else FILL.
- miss_req_in outside IDLE is ignored. The cache must hold it until ready_out falls.
- State WB: mem_req_out=1, mem_we_out=1, mem_addr_out={wb_line,k[1:0],2'b00}, mem_wdata_out=latched word k.
  - On mem_ack_in: k++. Address and data advance the next cycle; mem_req_out stays high with no idle gap.
  - Ack on beat LINE_WORDS-1: k=0, go to FILL.
- State FILL: begin_load_out=1, mem_req_out=1, mem_we_out=0, mem_addr_out={miss_line,k,2'b00}.
  - On mem_ack_in: ldata_out[32k+:32] <= mem_rdata_in, k++.
  - After the last beat: go to LOAD.
- State LOAD (1 cycle): mem_req_out=0, begin_load_out=1, load_en_out=1, ldata_out stable and complete. Next state IDLE.
- Leaving LOAD: begin_load_out=0, load_en_out=0, ready_out=1. ldata_out holds its last value until the next fill's first beat.
- mem_ack_in while mem_req_out=0 is ignored.
- Request rule: the memory may stall arbitrarily by holding mem_ack_in=0. Address, data and we stay stable while req=1 and ack=0.
- Latency with ack every cycle, counting from the miss_req_in sampling edge:
  - Clean miss: 4 FILL cycles + 1 LOAD cycle; ready_out returns at cycle 6.
  - Dirty miss: +4 WB cycles; ready_out returns at cycle 10.
- Beat order is always ascending from word 0. There is no critical-word-first and no wrap.

Decomposition:
- Shared package cache_pkg holds:
  - CACHE_LINE_SIZE=16, CACHE_LINE_BIT_NUM=128, LINE_WORDS=4
  - Line-offset field [3:0] and word-select field [3:2]
  - State enum {IDLE,WB,FILL,LOAD}
- One natural sub-module: mem_beat_seq, the beat counter plus address generator (line base, counter -> word address, last-beat flag), reused for WB and FILL.

Test Plan:
1. Clean fill: miss_addr=0xfff11110, dirty=0, ack every cycle, rdata=0,0x12345678,0,0 -> reads at 0xfff11110..1c; ldata_out=0x00000000_00000000_12345678_00000000 with load_en_out high exactly 1 cycle; ready_out back at cycle 6.
2. Dirty miss: wb_addr=0xaaaa0000, wbdata=0xffffffff_00000000_ffffffff_00000000, miss_addr=0xfff11110 -> 4 writes to 0xaaaa0000/04/08/0c with data 0,0xffffffff,0,0xffffffff; then 4 reads; load_en_out pulse; ready at cycle 10.
3. Stalls: ack held low 3 cycles on each beat -> mem_addr_out/mem_wdata_out stable during stalls; ldata_out correct; exactly one load_en_out pulse.
4. Reset mid-FILL after beat 2 -> all outputs at reset values immediately; no load_en_out; a subsequent clean miss completes normally.
5. Unaligned addr 0xfff1111c plus miss_req_in held high and re-asserted while busy -> fill starts at 0xfff11110; only one transfer performed.
6. Spurious mem_ack_in in IDLE and in LOAD -> no state change, no counter change.

Source files
------------

// File: rtl/cache_refill_ctrl_pkg.sv
// Shared cache line geometry, state encoding and address helpers
// for the refill engine and its beat sequencer.
package cache_pkg;

  localparam int ADDR_W             = 32;
  localparam int LINE_WORDS         = 4;
  localparam int CACHE_LINE_SIZE    = 16;
  localparam int CACHE_LINE_BIT_NUM = 128;

  localparam int OFS_LO  = 0;
  localparam int OFS_HI  = $clog2(CACHE_LINE_SIZE) - 1;
  localparam int WSEL_LO = 2;
  localparam int WSEL_HI = OFS_HI;

  typedef logic [ADDR_W-1:OFS_HI+1]       line_t;
  typedef logic [WSEL_HI-WSEL_LO:0]       wsel_t;
  typedef logic [CACHE_LINE_BIT_NUM-1:0]  line_data_t;

  typedef enum logic [1:0] {
    IDLE,
    WB,
    FILL,
    LOAD
  } state_e;

  function automatic logic [ADDR_W-1:0] beat_addr(
    input line_t l,
    input wsel_t k
  );
    return {l, k, {WSEL_LO{1'b0}}};
  endfunction

  function automatic line_t line_of(
    input logic [ADDR_W-1:0] a
  );
    return a[ADDR_W-1:OFS_HI+1];
  endfunction

endpackage

// File: rtl/cache_refill_ctrl_if.sv
// Cache-side miss/load bundle and word-wide memory bus bundle.
// The cache masters the miss side; the engine masters the memory side.
interface cache_miss_if;
  import cache_pkg::*;

  logic                miss_req_in;
  logic [ADDR_W-1:0]   miss_addr_in;
  logic                dirty_in;
  logic [ADDR_W-1:0]   wb_addr_in;
  line_data_t          wbdata_in;
  line_data_t          ldata_out;
  logic                begin_load_out;
  logic                load_en_out;
  logic                ready_out;

  modport master (
    output miss_req_in, miss_addr_in, dirty_in,
    output wb_addr_in, wbdata_in,
    input  ldata_out, begin_load_out,
    input  load_en_out, ready_out
  );

  modport slave (
    input  miss_req_in, miss_addr_in, dirty_in,
    input  wb_addr_in, wbdata_in,
    output ldata_out, begin_load_out,
    output load_en_out, ready_out
  );
endinterface

interface mem_bus_if;
  import cache_pkg::*;

  logic               mem_req_out;
  logic               mem_we_out;
  logic [ADDR_W-1:0]  mem_addr_out;
  logic [31:0]        mem_wdata_out;
  logic [31:0]        mem_rdata_in;
  logic               mem_ack_in;

  modport master (
    output mem_req_out, mem_we_out,
    output mem_addr_out, mem_wdata_out,
    input  mem_rdata_in, mem_ack_in
  );

  modport slave (
    input  mem_req_out, mem_we_out,
    input  mem_addr_out, mem_wdata_out,
    output mem_rdata_in, mem_ack_in
  );
endinterface

// File: rtl/cache_refill_ctrl_beat_seq.sv
// Beat counter and word-address generator, shared by the
// write-back and fill phases of the refill engine.
module mem_beat_seq
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  line_t             base,
  input  logic              adv,
  output logic [ADDR_W-1:0] addr,
  output wsel_t             k,
  output logic              last
);

  line_t base_q;
  wsel_t k_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base_q <= '0;
      k_q    <= '0;
    end else if (start) begin
      base_q <= base;
      k_q    <= '0;
    end else if (adv) begin
      k_q <= k_q + wsel_t'(1);
    end
  end

  assign addr = beat_addr(base_q, k_q);
  assign k    = k_q;
  assign last = (k_q == wsel_t'(LINE_WORDS - 1));

endmodule

// File: rtl/cache_refill_ctrl.sv
// Miss responder: writes back a dirty victim, fetches the new line
// beat by beat, then strobes the assembled line into the cache.
module cache_refill_ctrl
  import cache_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  cache_miss_if.slave cif,
  mem_bus_if.master   mif
);

  state_e     state_q;
  state_e     state_d;
  line_t      miss_line_q;
  line_data_t wb_sh_q;

  logic  ack;
  logic  seq_start;
  line_t seq_base;
  wsel_t k;
  logic  last;

  logic unused_ofs;
  assign unused_ofs = ^{cif.miss_addr_in[OFS_HI:OFS_LO],
                        cif.wb_addr_in[OFS_HI:OFS_LO]};

  // Only beats actually on the bus may be acknowledged.
  assign ack = mif.mem_ack_in & mif.mem_req_out;

  mem_beat_seq u_seq (
    .clk   (clk),
    .rst   (rst),
    .start (seq_start),
    .base  (seq_base),
    .adv   (ack),
    .addr  (mif.mem_addr_out),
    .k     (k),
    .last  (last)
  );

  always_comb begin
    state_d   = state_q;
    seq_start = 1'b0;
    seq_base  = miss_line_q;
    unique case (state_q)
      IDLE: begin
        if (cif.miss_req_in) begin
          seq_start = 1'b1;
          seq_base  = cif.dirty_in ?
                      line_of(cif.wb_addr_in) :
                      line_of(cif.miss_addr_in);
          state_d   = cif.dirty_in ? WB : FILL;
        end
      end
      WB: begin
        if (ack && last) begin
          seq_start = 1'b1;
          state_d   = FILL;
        end
      end
      FILL: begin
        if (ack && last) state_d = LOAD;
      end
      LOAD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  assign mif.mem_wdata_out = wb_sh_q[31:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      miss_line_q        <= '0;
      wb_sh_q            <= '0;
      cif.ldata_out      <= '0;
      cif.begin_load_out <= 1'b0;
      cif.load_en_out    <= 1'b0;
      cif.ready_out      <= 1'b1;
      mif.mem_req_out    <= 1'b0;
      mif.mem_we_out     <= 1'b0;
    end else begin
      if (state_q == IDLE && cif.miss_req_in) begin
        miss_line_q <= line_of(cif.miss_addr_in);
        wb_sh_q     <= cif.dirty_in ? cif.wbdata_in : '0;
      end else if (state_q == WB && ack) begin
        // Victim words leave lowest first; zeros shift in behind.
        wb_sh_q <= {32'd0, wb_sh_q[CACHE_LINE_BIT_NUM-1:32]};
      end
      if (state_q == FILL && ack)
        cif.ldata_out[{k, 5'd0} +: 32] <= mif.mem_rdata_in;
      cif.begin_load_out <= (state_d == FILL) || (state_d == LOAD);
      cif.load_en_out    <= (state_d == LOAD);
      cif.ready_out      <= (state_d == IDLE);
      mif.mem_req_out    <= (state_d == WB) || (state_d == FILL);
      mif.mem_we_out     <= (state_d == WB);
    end
  end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Randomized bench: a memory responder plus an expected-beat queue
// and line model checked against the refill engine.
module tb_cache_refill_ctrl;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  cache_miss_if cif();
  mem_bus_if    mif();

  cache_refill_ctrl dut (
    .clk (clk),
    .rst (rst),
    .cif (cif.slave),
    .mif (mif.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(
    input string        tag,
    input logic [127:0] got,
    input logic [127:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input int m);
    if (m == 1) return 3;
    if (m == 2) return int'($urandom_range(0, 3));
    return 0;
  endfunction

  task automatic check_reset_outs(input string tag);
    check({tag, "_ldata"}, cif.ldata_out, 0);
    check({tag, "_bl"}, cif.begin_load_out, 0);
    check({tag, "_le"}, cif.load_en_out, 0);
    check({tag, "_rdy"}, cif.ready_out, 1);
    check({tag, "_req"}, mif.mem_req_out, 0);
    check({tag, "_we"}, mif.mem_we_out, 0);
    check({tag, "_addr"}, mif.mem_addr_out, 0);
    check({tag, "_wdata"}, mif.mem_wdata_out, 0);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_ready", cif.ready_out, 1);
      check("idle_req", mif.mem_req_out, 0);
      check("idle_load_en", cif.load_en_out, 0);
      mif.mem_ack_in   = 1'($urandom_range(0, 1));
      mif.mem_rdata_in = $urandom;
    end
    @(negedge clk);
    mif.mem_ack_in = 1'b0;
  endtask

  task automatic run_miss(
    input logic [31:0]  ma,
    input logic         d,
    input logic [31:0]  wa,
    input logic [127:0] wd,
    input logic [127:0] rd,
    input int           smode,
    input bit           poke
  );
    logic        we_q[$];
    logic [31:0] ad_q[$];
    logic [31:0] dt_q[$];
    int          cyc;
    int          loads;
    int          stall;
    int          rix;
    bit          done;
    if (d) begin
      for (int i = 0; i < 4; i++) begin
        we_q.push_back(1'b1);
        ad_q.push_back({wa[31:4], 4'(i * 4)});
        dt_q.push_back(wd[32*i +: 32]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      we_q.push_back(1'b0);
      ad_q.push_back({ma[31:4], 4'(i * 4)});
      dt_q.push_back(32'd0);
    end
    @(negedge clk);
    check("pre_ready", cif.ready_out, 1);
    mif.mem_ack_in   = 1'b0;
    cif.miss_req_in  = 1'b1;
    cif.miss_addr_in = ma;
    cif.dirty_in     = d;
    cif.wb_addr_in   = wa;
    cif.wbdata_in    = wd;
    @(posedge clk);
    cyc   = 0;
    loads = 0;
    rix   = 0;
    done  = 0;
    stall = pick(smode);
    while (!done && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) check("ready_fall", cif.ready_out, 0);
      cif.miss_req_in = poke && (cyc == 2 || cyc == 3);
      if (poke) cif.miss_addr_in = $urandom;
      mif.mem_ack_in   = 1'b0;
      mif.mem_rdata_in = $urandom;
      if (mif.mem_req_out) begin
        if (we_q.size() == 0) begin
          check("extra_beat", mif.mem_req_out, 0);
        end else begin
          check("beat_we", mif.mem_we_out, we_q[0]);
          check("beat_addr", mif.mem_addr_out, ad_q[0]);
          if (we_q[0])
            check("beat_wdata", mif.mem_wdata_out, dt_q[0]);
          else
            check("fill_bl", cif.begin_load_out, 1);
          if (stall > 0) begin
            stall--;
          end else begin
            mif.mem_ack_in = 1'b1;
            if (!we_q[0]) begin
              mif.mem_rdata_in = rd[32*rix +: 32];
              rix++;
            end
            void'(we_q.pop_front());
            void'(ad_q.pop_front());
            void'(dt_q.pop_front());
            stall = pick(smode);
          end
        end
      end else if (cif.load_en_out || $urandom_range(0, 1) == 1) begin
        mif.mem_ack_in = 1'b1;
      end
      if (cif.load_en_out) begin
        loads++;
        check("load_ldata", cif.ldata_out, rd);
        check("load_left", we_q.size(), 0);
        check("load_req", mif.mem_req_out, 0);
        check("load_bl", cif.begin_load_out, 1);
      end
      if (cif.ready_out) begin
        done = 1;
        if (smode == 0) check("ready_cycle", cyc, d ? 10 : 6);
        check("end_bl", cif.begin_load_out, 0);
        check("end_ldata_hold", cif.ldata_out, rd);
      end
    end
    check("timeout", done, 1);
    check("load_pulses", loads, 1);
    cif.miss_req_in = 1'b0;
    mif.mem_ack_in  = 1'b0;
  endtask

  task automatic reset_mid_fill();
    logic [31:0] ma;
    int          loads;
    ma = $urandom;
    loads = 0;
    @(negedge clk);
    cif.miss_req_in  = 1'b1;
    cif.miss_addr_in = ma;
    cif.dirty_in     = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cif.miss_req_in  = 1'b0;
    mif.mem_ack_in   = 1'b1;
    mif.mem_rdata_in = $urandom;
    @(negedge clk);
    mif.mem_rdata_in = $urandom;
    @(negedge clk);
    check("rst_pre_addr", mif.mem_addr_out, {ma[31:4], 4'h8});
    mif.mem_ack_in = 1'b0;
    rst = 1'b0;
    #1;
    check_reset_outs("rst_mid");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mif.mem_ack_in = 1'($urandom_range(0, 1));
      if (cif.load_en_out) loads++;
    end
    rst = 1'b1;
    mif.mem_ack_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (cif.load_en_out) loads++;
    end
    check("rst_no_load", loads, 0);
    check_reset_outs("rst_after");
  endtask

  initial begin
    logic [31:0]  ma;
    logic [31:0]  wa;
    logic [127:0] wd;
    logic [127:0] rd;
    n_cmp = 0;
    n_err = 0;
    rst              = 1'b0;
    cif.miss_req_in  = 1'b0;
    cif.miss_addr_in = '0;
    cif.dirty_in     = 1'b0;
    cif.wb_addr_in   = '0;
    cif.wbdata_in    = '0;
    mif.mem_rdata_in = '0;
    mif.mem_ack_in   = 1'b0;
    #12;
    check_reset_outs("reset");
    @(negedge clk);
    rst = 1'b1;
    idle_cycles(4);

    run_miss(32'hfff11110, 1'b0, 32'h0, 128'h0,
             128'h00000000_00000000_12345678_00000000, 0, 0);
    idle_cycles(2);
    run_miss(32'hfff11110, 1'b1, 32'haaaa0000,
             128'hffffffff_00000000_ffffffff_00000000,
             {$urandom, $urandom, $urandom, $urandom}, 0, 0);
    idle_cycles(2);
    run_miss($urandom, 1'b1, $urandom,
             {$urandom, $urandom, $urandom, $urandom},
             {$urandom, $urandom, $urandom, $urandom}, 1, 0);
    idle_cycles(2);
    reset_mid_fill();
    run_miss($urandom, 1'b0, $urandom, 128'h0,
             {$urandom, $urandom, $urandom, $urandom}, 0, 0);
    idle_cycles(2);
    run_miss(32'hfff1111c, 1'b0, 32'h0, 128'h0,
             {$urandom, $urandom, $urandom, $urandom}, 0, 1);
    idle_cycles(4);

    for (int t = 0; t < 20; t++) begin
      ma = $urandom;
      wa = $urandom;
      wd = {$urandom, $urandom, $urandom, $urandom};
      rd = {$urandom, $urandom, $urandom, $urandom};
      run_miss(ma, 1'($urandom_range(0, 1)), wa, wd, rd,
               2, bit'($urandom_range(0, 1)));
      idle_cycles(int'($urandom_range(1, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
